// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the program counter and sequences instruction fetch.
// Next PC comes from one of three sources: pc+4, pc+offset or jalr_base+offset.
// Fetch uses a req/ready handshake, then waits for instr_valid. The PC holds
// while the execute stage stalls. A misaligned target traps, and the trap
// stays set until reset.
//
// Ports:
//   clk, reset      : single rising-edge clock, asynchronous active-high reset
//   imem_req/addr   : fetch request and address; the address is always pc
//   imem_ready      : memory accepts the request this cycle
//   instr_valid     : fetched instruction available; used only in WAIT
//   stall           : execute stage not ready; hold pc and retired
//   branch_taken    : conditional branch or JAL taken (sampled in EXEC)
//   jalr            : JALR in EXEC; it takes priority over branch_taken
//   offset          : sign-extended immediate
//   jalr_base       : rs1 value for JALR
//   pc, pc_plus4    : current pc and pc+4 for the link register
//   exec_valid      : instruction live in EXEC
//   redirect        : one-cycle pulse after a non-sequential pc update
//   trap            : sticky misaligned-target trap
//   retired         : count of retired instructions, wraps modulo 2^32

module pc_sequencer #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   // Only XLEN = 32 is supported.
   parameter int          XLEN         = 32
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ready,
   input  logic            instr_valid,
   input  logic            stall,
   input  logic            branch_taken,
   input  logic            jalr,
   input  logic [XLEN-1:0] offset,
   input  logic [XLEN-1:0] jalr_base,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus4,
   output logic            exec_valid,
   output logic            redirect,
   output logic            trap,
   output logic [31:0]     retired
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REQ  = 3'd1,
      WAIT = 3'd2,
      EXEC = 3'd3,
      TRAP = 3'd4
   } state_t;

   state_t          r_state;
   logic [XLEN-1:0] r_pc;
   logic [31:0]     r_retired;
   logic            r_req;
   logic            r_exec;
   logic            r_redirect;
   logic            r_trap;

   logic [XLEN-1:0] w_plus4;
   logic [XLEN-1:0] w_br_sum;
   logic [XLEN-1:0] w_jalr_sum;
   logic [XLEN-1:0] w_target;
   logic            w_misaligned;
   logic            w_nonseq;

   // All sums are plain modulo-2^32 adds. The JALR target has bit 0
   // cleared before the alignment test, so only bit 1 can trap there.
   always_comb begin
      w_plus4    = r_pc + 32'd4;
      w_br_sum   = r_pc + offset;
      w_jalr_sum = jalr_base + offset;
      w_target   = w_plus4;
      if (jalr) begin
         w_target = {w_jalr_sum[XLEN-1:1], 1'b0};
      end else if (branch_taken) begin
         w_target = w_br_sum;
      end
      w_misaligned = |w_target[1:0];
      w_nonseq     = jalr | branch_taken;
   end

   // Single FSM. Every output is a register that is loaded for the state
   // being entered. As a result, the outputs change on the same edge as
   // the state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= IDLE;
         r_pc       <= RESET_VECTOR;
         r_retired  <= 32'd0;
         r_req      <= 1'b0;
         r_exec     <= 1'b0;
         r_redirect <= 1'b0;
         r_trap     <= 1'b0;
      end else begin
         r_redirect <= 1'b0;
         case (r_state)
            IDLE: begin
               r_state <= REQ;
               r_req   <= 1'b1;
            end
            REQ: begin
               if (imem_ready) begin
                  r_state <= WAIT;
                  r_req   <= 1'b0;
               end
            end
            WAIT: begin
               if (instr_valid) begin
                  r_state <= EXEC;
                  r_exec  <= 1'b1;
               end
            end
            EXEC: begin
               if (!stall) begin
                  r_exec <= 1'b0;
                  if (w_misaligned) begin
                     r_state <= TRAP;
                     r_trap  <= 1'b1;
                  end else begin
                     r_state    <= REQ;
                     r_req      <= 1'b1;
                     r_pc       <= w_target;
                     r_retired  <= r_retired + 32'd1;
                     r_redirect <= w_nonseq;
                  end
               end
            end
            TRAP: begin
               r_state <= TRAP;
               r_req   <= 1'b0;
               r_exec  <= 1'b0;
               r_trap  <= 1'b1;
            end
            default: begin
               r_state <= IDLE;
               r_req   <= 1'b0;
               r_exec  <= 1'b0;
            end
         endcase
      end
   end

   assign imem_req   = r_req;
   assign imem_addr  = r_pc;
   assign pc         = r_pc;
   assign pc_plus4   = w_plus4;
   assign exec_valid = r_exec;
   assign redirect   = r_redirect;
   assign trap       = r_trap;
   assign retired    = r_retired;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed, self-checking bench for pc_sequencer.
// It covers reset, fetch handshake, branch/jalr, stall, wrap, trap and async reset.

module tb_pc_sequencer;

   logic        clk;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        instr_valid;
   logic        stall;
   logic        branch_taken;
   logic        jalr;
   logic [31:0] offset;
   logic [31:0] jalr_base;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        exec_valid;
   logic        redirect;
   logic        trap;
   logic [31:0] retired;

   int checks = 0;
   int errors = 0;

   pc_sequencer #(.RESET_VECTOR(32'h0000_0100), .XLEN(32)) dut (
      .clk          (clk),
      .reset        (reset),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ready   (imem_ready),
      .instr_valid  (instr_valid),
      .stall        (stall),
      .branch_taken (branch_taken),
      .jalr         (jalr),
      .offset       (offset),
      .jalr_base    (jalr_base),
      .pc           (pc),
      .pc_plus4     (pc_plus4),
      .exec_valid   (exec_valid),
      .redirect     (redirect),
      .trap         (trap),
      .retired      (retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic go_exec();
      int n = 0;
      while (exec_valid !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk("exec_reached", {31'd0, exec_valid}, 32'd1);
   endtask

   task automatic clr_ctl();
      branch_taken = 1'b0;
      jalr         = 1'b0;
      offset       = 32'd0;
      jalr_base    = 32'd0;
   endtask

   task automatic run(input logic br, input logic jr,
                      input logic [31:0] off, input logic [31:0] base);
      go_exec();
      branch_taken = br;
      jalr         = jr;
      offset       = off;
      jalr_base    = base;
      tick();
      clr_ctl();
   endtask

   initial begin
      reset       = 1'b1;
      imem_ready  = 1'b1;
      instr_valid = 1'b1;
      stall       = 1'b0;
      clr_ctl();
      tick();
      tick();
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_pc", pc, 32'h100);
      chk("rst_exec", {31'd0, exec_valid}, 32'd0);
      chk("rst_redir", {31'd0, redirect}, 32'd0);
      chk("rst_trap", {31'd0, trap}, 32'd0);
      chk("rst_ret", retired, 32'd0);

      reset = 1'b0;
      tick();
      chk("idle_req", {31'd0, imem_req}, 32'd1);
      chk("idle_addr", imem_addr, 32'h100);

      run(1'b0, 1'b0, 32'd0, 32'd0);
      run(1'b0, 1'b0, 32'd0, 32'd0);
      run(1'b0, 1'b0, 32'd0, 32'd0);
      chk("seq_pc", pc, 32'h10C);
      chk("seq_ret", retired, 32'd3);
      chk("seq_redir", {31'd0, redirect}, 32'd0);
      chk("seq_req", {31'd0, imem_req}, 32'd1);

      imem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("hold_req", {31'd0, imem_req}, 32'd1);
         chk("hold_addr", imem_addr, 32'h10C);
      end
      imem_ready = 1'b1;
      tick();
      chk("wait_req", {31'd0, imem_req}, 32'd0);
      chk("wait_exec", {31'd0, exec_valid}, 32'd0);
      tick();
      chk("exec_on", {31'd0, exec_valid}, 32'd1);

      run(1'b0, 1'b1, 32'd0, 32'h200);
      chk("jr_pc", pc, 32'h200);
      chk("jr_redir", {31'd0, redirect}, 32'd1);
      tick();
      chk("redir_pulse", {31'd0, redirect}, 32'd0);

      run(1'b1, 1'b0, 32'hFFFF_FFF0, 32'd0);
      chk("br_pc", pc, 32'h1F0);
      chk("br_redir", {31'd0, redirect}, 32'd1);

      run(1'b1, 1'b1, 32'd4, 32'h401);
      chk("prio_pc", pc, 32'h404);
      chk("prio_ret", retired, 32'd6);

      go_exec();
      stall        = 1'b1;
      branch_taken = 1'b1;
      offset       = 32'h10;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("stall_pc", pc, 32'h404);
         chk("stall_ret", retired, 32'd6);
         chk("stall_exec", {31'd0, exec_valid}, 32'd1);
      end
      stall = 1'b0;
      tick();
      clr_ctl();
      chk("unstall_pc", pc, 32'h414);
      chk("unstall_ret", retired, 32'd7);
      chk("unstall_redir", {31'd0, redirect}, 32'd1);

      run(1'b0, 1'b1, 32'd0, 32'hFFFF_FFFC);
      chk("top_pc", pc, 32'hFFFF_FFFC);
      chk("top_plus4", pc_plus4, 32'd0);
      run(1'b0, 1'b0, 32'd0, 32'd0);
      chk("wrap_pc", pc, 32'd0);
      chk("wrap_ret", retired, 32'd9);
      chk("wrap_redir", {31'd0, redirect}, 32'd0);

      run(1'b1, 1'b0, 32'd6, 32'd0);
      chk("trap_on", {31'd0, trap}, 32'd1);
      chk("trap_pc", pc, 32'd0);
      chk("trap_ret", retired, 32'd9);
      chk("trap_exec", {31'd0, exec_valid}, 32'd0);
      chk("trap_req", {31'd0, imem_req}, 32'd0);
      branch_taken = 1'b1;
      jalr         = 1'b1;
      jalr_base    = 32'h800;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("trap_stick", {31'd0, trap}, 32'd1);
         chk("trap_hold_req", {31'd0, imem_req}, 32'd0);
         chk("trap_hold_pc", pc, 32'd0);
      end
      chk("trap_plus4", pc_plus4, 32'd4);
      clr_ctl();

      #2 reset = 1'b1;
      #1;
      chk("arst_trap", {31'd0, trap}, 32'd0);
      chk("arst_pc", pc, 32'h100);
      chk("arst_ret", retired, 32'd0);
      reset = 1'b0;
      tick();
      chk("rel_req", {31'd0, imem_req}, 32'd1);

      run(1'b1, 1'b0, 32'd8, 32'd0);
      chk("pre_req_pc", pc, 32'h108);
      chk("pre_req_redir", {31'd0, redirect}, 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("mreq_req", {31'd0, imem_req}, 32'd0);
      chk("mreq_redir", {31'd0, redirect}, 32'd0);
      chk("mreq_pc", pc, 32'h100);
      chk("mreq_ret", retired, 32'd0);
      reset = 1'b0;
      tick();

      run(1'b0, 1'b0, 32'd0, 32'd0);
      chk("pre_ex_pc", pc, 32'h104);
      go_exec();
      branch_taken = 1'b1;
      offset       = 32'h40;
      #2 reset = 1'b1;
      #1;
      chk("mex_exec", {31'd0, exec_valid}, 32'd0);
      chk("mex_pc", pc, 32'h100);
      chk("mex_ret", retired, 32'd0);
      reset = 1'b0;
      clr_ctl();
      tick();
      chk("post_req", {31'd0, imem_req}, 32'd1);
      chk("post_addr", imem_addr, 32'h100);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Owns the program counter and sequences instruction fetch for the core. Computes the next PC from one of three sources: PC+4, PC+branch offset, or JALR base+offset. Performs a request/ready/valid handshake with instruction memory and holds the PC during stalls. Traps on a misaligned target. Sits between the instruction-memory port and the decode/execute stage; its branch-target arithmetic is the same PC+offset computation used by the branch datapath.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
XLEN, 32, datapath width; only 32 is supported

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high
imem_req  out  1  fetch request to instruction memory
imem_addr  out  XLEN  fetch address; equals pc
imem_ready  in  1  memory accepts request this cycle
instr_valid  in  1  fetched instruction available this cycle
stall  in  1  execute stage not ready to retire; hold PC
branch_taken  in  1  conditional branch or JAL taken, sampled in EXEC
jalr  in  1  current instruction is JALR, sampled in EXEC
offset  in  XLEN  sign-extended immediate
jalr_base  in  XLEN  rs1 value for JALR
pc  out  XLEN  current PC
pc_plus4  out  XLEN  pc+4, combinational, for link-register writeback
exec_valid  out  1  high in EXEC; instruction is live for decode/execute
redirect  out  1  one-cycle pulse when PC updates to a non-sequential target
trap  out  1  misaligned-target trap, sticky until reset
retired  out  32  count of retired instructions

Behaviour:
- Reset (asynchronous, any state, including mid-handshake): state=IDLE, pc=RESET_VECTOR, imem_req=0, exec_valid=0, redirect=0, trap=0, retired=0. Any outstanding request is abandoned.
- States: IDLE, REQ, WAIT, EXEC, TRAP.
- IDLE: outputs idle. Moves to REQ on the next clock, giving one cycle of latency after reset release.
- REQ: imem_req=1 and imem_addr=pc. Both stay stable until imem_ready is sampled high, then move to WAIT.
- WAIT: imem_req=0. Moves to EXEC on the first cycle instr_valid=1. instr_valid is ignored in all other states.
- EXEC: exec_valid=1.
  - If stall=1: hold state, pc, and retired.
  - If stall=0, compute the target:
    - jalr=1: (jalr_base+offset) with bit0 cleared. jalr has priority over branch_taken.
    - else branch_taken=1: pc+offset.
    - else: pc+4.
  - Then on the same edge:
    - If target[1:0]!=0: go to TRAP. pc is unchanged, trap=1, retired is not incremented.
    - Otherwise: pc<=target, retired<=retired+1, go to REQ. redirect pulses for 1 cycle (registered, visible in the next cycle) when jalr or branch_taken caused the update.
- TRAP: all requests off, exec_valid=0, trap=1. Leaves only on reset.
- Arithmetic: all additions are 32-bit modulo with no overflow flag. 0xFFFF_FFFC+4=0. offset is treated as two's complement. retired wraps from 0xFFFF_FFFF to 0.
- Minimum fetch loop with imem_ready and instr_valid both immediate: REQ→WAIT→EXEC, i.e. 3 cycles per instruction.
- pc_plus4 always equals pc+4, including in TRAP.

Test Plan:
- Reset release with RESET_VECTOR=0x100 and immediate ready/valid → imem_addr=0x100 in REQ; after 3 instructions with no branches, pc=0x10C and retired=3.
- imem_ready low for 4 cycles in REQ → imem_req and imem_addr=pc held stable for all 4 cycles; WAIT is entered only after ready.
- EXEC with pc=0x200, branch_taken=1, offset=0xFFFF_FFF0 → pc=0x1F0, redirect high for 1 cycle. Repeat with jalr=1 also set, jalr_base=0x401, offset=4 → pc=0x404 (jalr wins, bit0 cleared).
- stall high 5 cycles in EXEC with branch_taken=1 → pc and retired unchanged during the stall; update happens on the first cycle stall=0. Separately, pc=0xFFFF_FFFC with sequential advance → pc=0x0000_0000.
- branch_taken=1, offset=0x6 from pc=0x0 → TRAP, trap=1, pc=0x0, retired unchanged. Further stimulus has no effect until reset.
- Assert reset asynchronously mid-REQ and mid-EXEC → outputs return to reset values immediately, without waiting for a clock edge.
